// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op codes, FSM states
// and small decode helpers used when an operation is latched.
// No ports; imported by muldiv_iter and muldiv_unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div(op_e o);
    return o[2];
  endfunction

  // Signedness of one operand: rs2 = 0 asks about rs1 (a), rs2 = 1 about rs2 (b).
  // MULHSU is the only op where the two operands differ.
  function automatic logic is_signed(op_e o, logic rs2);
    logic s;
    case (o)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      OP_MULHSU:                       s = ~rs2;
      default:                         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative engine: one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle on a 2*WIDTH accumulator; WIDTH steps per operation.
// No backpressure; the owner pulses load once and asserts step while computing.
// Ports: clk, rst_n; load/div_mode/opa/opb start an op; step advances one
// iteration; last flags the final step; acc_nxt is the accumulator after the
// current step (product, or {remainder, quotient} for divide).
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               last,
  output logic [2*WIDTH-1:0] acc_nxt
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               div_q;
  logic [CW-1:0]      cnt_q;

  // Multiply: multiplier sits in the low half and shifts out LSB first; the
  // multiplicand is added into the high half with a carry bit before shifting.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  // Divide: partial remainder is the high half with the next dividend bit
  // shifted in (WIDTH+1 bits); the extra MSB of diff is the borrow.
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               qbit;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opb_q};
    qbit    = ~diff[WIDTH+1];
    new_rem = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    div_nxt = {new_rem, acc_q[WIDTH-2:0], qbit};

    acc_nxt = div_q ? div_nxt : mul_nxt;
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= {{WIDTH{1'b0}}, opa};
      opb_q <= opb;
      div_q <= div_mode;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: sign handling, special-case override and control
// FSM around the unsigned iterative engine.
// Latency WIDTH+1 cycles from accepting edge to done for every op; no queueing,
// start is ignored while busy and flush abandons the op without a done.
// Ports: clk, rst_n (async, active-low); start/op/a/b request an op (sampled when
// not busy); flush aborts; busy while computing; done one-cycle strobe; result
// held until the next completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;
  logic   load, step, wr;

  // Decode of the request as presented this cycle.
  op_e              op_in;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             b_zero, ovf;

  always_comb begin
    op_in  = op_e'(op);
    sgn_a  = is_signed(op_in, 1'b0) & a[WIDTH-1];
    sgn_b  = is_signed(op_in, 1'b1) & b[WIDTH-1];
    mag_a  = sgn_a ? (~a + WIDTH'(1)) : a;
    mag_b  = sgn_b ? (~b + WIDTH'(1)) : b;
    b_zero = (b == '0);
    ovf    = (op_in == OP_DIV || op_in == OP_REM) && (a == MOST_NEG) && (&b);
  end

  // Attributes of the op in flight.
  op_e  op_q;
  logic neg_a_q, neg_b_q, b_zero_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      op_q     <= op_in;
      neg_a_q  <= sgn_a;
      neg_b_q  <= sgn_b;
      b_zero_q <= b_zero;
      ovf_q    <= ovf;
    end
  end

  logic                 last;
  logic [2*WIDTH-1:0]   acc_nxt;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .div_mode (is_div(op_in)),
    .opa      (mag_a),
    .opb      (mag_b),
    .last     (last),
    .acc_nxt  (acc_nxt)
  );

  // Final value is formed from the engine's post-step accumulator during the
  // last CALC cycle so that result is already valid while done is high.
  logic               neg_q;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, res_d;

  always_comb begin
    neg_q  = neg_a_q ^ neg_b_q;
    prod_s = neg_q ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
    quot_s = neg_q ? (~acc_nxt[WIDTH-1:0] + WIDTH'(1)) : acc_nxt[WIDTH-1:0];
    // Remainder follows the dividend's sign.
    rem_s  = neg_a_q ? (~acc_nxt[2*WIDTH-1:WIDTH] + WIDTH'(1))
                     : acc_nxt[2*WIDTH-1:WIDTH];
    res_d  = '0;
    case (op_q)
      OP_MUL:                       res_d = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: begin
        if (b_zero_q)   res_d = '1;
        else if (ovf_q) res_d = MOST_NEG;
        else            res_d = quot_s;
      end
      default: begin
        // Divide by zero leaves the whole dividend in the remainder, and the
        // dividend sign restores it, so rem_s already equals a in that case.
        if (ovf_q) res_d = '0;
        else       res_d = rem_s;
      end
    endcase
  end

  // Control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          load    = 1'b1;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (last) begin
          state_d = ST_DONE;
          wr      = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_CALC;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything, including a simultaneous start.
    if (flush) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      wr      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  result <= '0;
    else if (wr) result <= res_d;
  end

  assign busy = (state_q == ST_CALC);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       nm;
  } exp_t;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    string       nm;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with result 0x%0h expected no done (cyc=%0d)",
                 result, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.nm, "_result"}, 64'(result), 64'(e.res));
        check({e.nm, "_cycle"}, 64'(cyc), 64'(e.at));
        check({e.nm, "_busy_with_done"}, 64'(busy), 64'd0);
      end
    end
  end

  // Drive a request; caller sits at a negedge. Accepted on the following
  // posedge, so done is due 32 edges later (33rd cycle counting the accept
  // cycle as the first). Operands are scrambled afterwards to prove latching.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input string nm, input bit want_done);
    exp_t item;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
    if (want_done) begin
      item.res = e;
      item.at  = cyc + 32;
      item.nm  = nm;
      sbq.push_back(item);
    end
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    vt.push_back('{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7xm3"});
    vt.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_minsq"});
    vt.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"});
    vt.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1"});
    vt.push_back('{3'b001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, "mulh_m1x1"});
    vt.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "div_m7_2"});
    vt.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, "rem_m7_2"});
    vt.push_back('{3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, "divu_big_2"});
    vt.push_back('{3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, "div_by0"});
    vt.push_back('{3'b111, 32'h00000005, 32'h00000000, 32'h00000005, "remu_by0"});
    vt.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, "rem_neg_by0"});
    vt.push_back('{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, "divu_by0"});
    vt.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"});
    vt.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"});
    vt.push_back('{3'b110, 32'd100,      32'd7,        32'd2,        "rem_100_7"});
    vt.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       "divu_100_7"});

    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    // Directed vectors, one at a time.
    foreach (vt[i]) begin
      @(negedge clk);
      issue(vt[i].o, vt[i].x, vt[i].y, vt[i].e, vt[i].nm, 1'b1);
      check({vt[i].nm, "_busy_after_accept"}, 64'(busy), 64'd1);
      wait_drain(vt[i].nm);
    end

    // Flush partway through a DIV: no done, result keeps 14.
    repeat (3) @(negedge clk);
    issue(3'b100, 32'd1000, 32'd3, 32'd0, "div_flushed", 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_result_kept", 64'(result), 64'd14);

    // Flush and start together: flush wins, nothing starts.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b000;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Start during CALC is dropped; only one done, carrying 2*3.
    @(negedge clk);
    issue(3'b000, 32'd2, 32'd3, 32'd6, "mul_ign", 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd100;
    b     = 32'd100;
    @(negedge clk);
    start = 1'b0;
    wait_drain("mul_ign");
    repeat (40) @(negedge clk);
    check("ign_result_held", 64'(result), 64'd6);

    // Back-to-back: start presented during the DONE cycle.
    @(negedge clk);
    issue(3'b011, 32'h00010000, 32'h00010000, 32'h00000001, "mulhu_b2b_1", 1'b1);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    check("b2b_done_seen", 64'(done), 64'd1);
    issue(3'b000, 32'd1234, 32'd1000, 32'd1234000, "mul_b2b_2", 1'b1);
    wait_drain("b2b");

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    issue(3'b000, 32'd5, 32'd6, 32'd30, "mul_reset", 1'b1);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 32'd12, "mul_after_reset", 1'b1);
    wait_drain("mul_after_reset");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
